fb_ram_loader: RTL and testbench
================================

FB_RAM_LOADER -- requirements
Module: fb_ram_loader

Interface
REQ-001 SHALL have parameter ADDRESS_WIDTH, default 6, RAM address width (depth 2^ADDRESS_WIDTH = 64 words).
REQ-002 SHALL have parameter DATA_WIDTH, default 10, RAM word width.
REQ-003 SHALL have port clk  input  1  clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port ld_valid  input  1  load word valid.
REQ-006 SHALL have port ld_data  input  DATA_WIDTH  load word.
REQ-007 SHALL have port ld_last  input  1  marks final program word (qualified by ld_valid).
REQ-008 SHALL have port ld_ready  output  1  loader accepts a word this cycle.
REQ-009 SHALL have port cpu_rst  output  1  reset to the downstream CPU, active-high.
REQ-010 SHALL have port load_done  output  1  program loaded, CPU running.
REQ-011 SHALL have port load_err  output  1  load failed, sticky until rst.
REQ-012 SHALL have port word_count  output  ADDRESS_WIDTH+1  number of words loaded (0..64).
REQ-013 SHALL have port cpu_mar  input  ADDRESS_WIDTH  CPU address.
REQ-014 SHALL have port cpu_mdr_in  input  DATA_WIDTH  CPU write data.
REQ-015 SHALL have port cpu_ram_wr  input  1  CPU write enable.
REQ-016 SHALL have port cpu_mdr_out  output  DATA_WIDTH  CPU read data, registered.

Function
REQ-017 SHALL implement FSM states LOAD, CHECK (macro only), RUN, ERROR; a transfer is ld_valid && ld_ready at a rising edge.
REQ-018 LOAD: ld_ready=1, cpu_rst=1; each transfer writes ld_data to mem[word_count[5:0]] and increments word_count.
REQ-019 LOAD: a transfer with ld_last=1 SHALL go to CHECK if FB_LOADER_CHECKSUM_EN is defined, else RUN, on the same edge.
REQ-020 LOAD: the 64th transfer with ld_last=0 SHALL be written, set word_count=64 and go to ERROR (overflow).
REQ-021 LOAD: ld_valid=0 cycles SHALL hold all state; there is no timeout.
REQ-022 RUN: ld_ready=0, cpu_rst=0, load_done=1; cpu_rst SHALL first read 0 in the cycle after the last/checksum transfer.
REQ-023 RUN: cpu_mdr_out SHALL equal mem[cpu_mar] sampled at the previous edge (1-cycle read latency), or 0 if cpu_mar >= word_count at that edge.
REQ-024 RUN: cpu_ram_wr=1 SHALL write cpu_mdr_in to mem[cpu_mar] at the edge; a same-address read in that cycle SHALL return old data (read-before-write).
REQ-025 RUN: CPU writes at cpu_mar >= word_count SHALL be stored and SHALL raise word_count to cpu_mar+1.
REQ-026 ERROR: ld_ready=0, cpu_rst=1, load_done=0, load_err=1; exit only by rst.
REQ-027 Outside RUN, cpu_mdr_out SHALL be 0 and cpu_ram_wr SHALL be ignored.
REQ-028 ld_ready, cpu_rst, load_done, load_err SHALL be decoded from registered state only (no combinational path from inputs).

Reset
REQ-029 rst SHALL set state=LOAD, word_count=0, cpu_mdr_out=0, load_done=0, load_err=0, cpu_rst=1; ld_ready SHALL be 1 in the first cycle after rst deasserts.
REQ-030 rst asserted mid-load or in RUN SHALL abort at that edge and restart loading at address 0; memory contents need not be cleared (hidden by REQ-023).

Configuration
REQ-031 Macro FB_LOADER_CHECKSUM_EN defined: loader SHALL keep a DATA_WIDTH-bit modulo-2^DATA_WIDTH sum of loaded words; in CHECK (ld_ready=1, cpu_rst=1) the next transfer is the checksum, not stored, not counted; match -> RUN, mismatch -> ERROR.
REQ-032 Macro undefined: no CHECK state or sum register; ld_last goes directly to RUN.

Verification
REQ-033 Load 3'h words 0x001,0x002,0x003 (last on 3rd) -> word_count=3, cpu_rst falls next cycle, read cpu_mar=1 returns 0x002 one cycle later, cpu_mar=5 returns 0.
REQ-034 64 transfers, ld_last never set -> word_count=64, load_err=1, cpu_rst stays 1, ld_ready=0.
REQ-035 RUN: write 0x155 to addr 10 (word_count=3) -> word_count=11, read addr 10 returns 0x155; same-cycle read returns old value 0.
REQ-036 Checksum macro on: load 0x3FF,0x002 then checksum 0x001 -> RUN; repeat with checksum 0x000 -> ERROR, load_err=1.
REQ-037 Toggle ld_valid every other cycle during load, assert rst after 2nd word -> word_count=0, ld_ready=1, reload of 1 word succeeds.

Source files
------------

// File: rtl/fb_ram_loader.sv
// Boot loader that streams a program into a local RAM while holding the CPU in reset, then hands the RAM over.
// Optional feature: define FB_LOADER_CHECKSUM_EN to verify a trailing modulo-2^DATA_WIDTH checksum word.
module fb_ram_loader #(
    parameter int ADDRESS_WIDTH = 6,
    parameter int DATA_WIDTH    = 10
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     ld_valid,
    input  logic [DATA_WIDTH-1:0]    ld_data,
    input  logic                     ld_last,
    output logic                     ld_ready,
    output logic                     cpu_rst,
    output logic                     load_done,
    output logic                     load_err,
    output logic [ADDRESS_WIDTH:0]   word_count,
    input  logic [ADDRESS_WIDTH-1:0] cpu_mar,
    input  logic [DATA_WIDTH-1:0]    cpu_mdr_in,
    input  logic                     cpu_ram_wr,
    output logic [DATA_WIDTH-1:0]    cpu_mdr_out
);

    localparam int DEPTH = 1 << ADDRESS_WIDTH;
    localparam int CW    = ADDRESS_WIDTH + 1;

`ifdef FB_LOADER_CHECKSUM_EN
    typedef enum logic [1:0] {
        ST_LOAD  = 2'd0,
        ST_CHECK = 2'd1,
        ST_RUN   = 2'd2,
        ST_ERROR = 2'd3
    } state_t;
`else
    typedef enum logic [1:0] {
        ST_LOAD  = 2'd0,
        ST_RUN   = 2'd2,
        ST_ERROR = 2'd3
    } state_t;
`endif

    state_t                   state_q, state_d;
    logic [CW-1:0]            word_count_q, word_count_d;
    logic [DATA_WIDTH-1:0]    cpu_mdr_out_q, cpu_mdr_out_d;
`ifdef FB_LOADER_CHECKSUM_EN
    logic [DATA_WIDTH-1:0]    sum_q, sum_d;
`endif

    logic [DATA_WIDTH-1:0]    mem [DEPTH];
    logic                     mem_we;
    logic [ADDRESS_WIDTH-1:0] mem_waddr;
    logic [DATA_WIDTH-1:0]    mem_wdata;
    logic                     xfer;
    logic [CW-1:0]            cpu_mar_ext;

    // Status outputs decode the registered state only, so no input reaches them combinationally.
`ifdef FB_LOADER_CHECKSUM_EN
    assign ld_ready = (state_q == ST_LOAD) || (state_q == ST_CHECK);
`else
    assign ld_ready = (state_q == ST_LOAD);
`endif
    assign cpu_rst     = (state_q != ST_RUN);
    assign load_done   = (state_q == ST_RUN);
    assign load_err    = (state_q == ST_ERROR);
    assign word_count  = word_count_q;
    assign cpu_mdr_out = cpu_mdr_out_q;

    assign xfer        = ld_valid && ld_ready;
    assign cpu_mar_ext = {1'b0, cpu_mar};

    always_comb begin
        // NOTE: every signal gets a default first so no path through the case infers a latch.
        state_d       = state_q;
        word_count_d  = word_count_q;
        cpu_mdr_out_d = '0;
        mem_we        = 1'b0;
        mem_waddr     = word_count_q[ADDRESS_WIDTH-1:0];
        mem_wdata     = ld_data;
`ifdef FB_LOADER_CHECKSUM_EN
        sum_d         = sum_q;
`endif
        case (state_q)
            ST_LOAD: begin
                if (xfer) begin
                    mem_we       = 1'b1;
                    word_count_d = word_count_q + CW'(1);
`ifdef FB_LOADER_CHECKSUM_EN
                    sum_d        = sum_q + ld_data;
                    if (ld_last) state_d = ST_CHECK;
`else
                    if (ld_last) state_d = ST_RUN;
`endif
                    else if (word_count_q == CW'(DEPTH - 1)) state_d = ST_ERROR;
                end
            end
`ifdef FB_LOADER_CHECKSUM_EN
            ST_CHECK: begin
                // The checksum word is compared only; it is neither stored nor counted.
                if (xfer) state_d = (ld_data == sum_q) ? ST_RUN : ST_ERROR;
            end
`endif
            ST_RUN: begin
                // Addresses beyond the loaded image read as zero, hiding stale RAM contents.
                if (cpu_mar_ext < word_count_q) cpu_mdr_out_d = mem[cpu_mar];
                if (cpu_ram_wr) begin
                    mem_we    = 1'b1;
                    mem_waddr = cpu_mar;
                    mem_wdata = cpu_mdr_in;
                    if (cpu_mar_ext >= word_count_q) word_count_d = cpu_mar_ext + CW'(1);
                end
            end
            ST_ERROR: ;
            default: state_d = ST_LOAD;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all flops sample pre-edge values together.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_LOAD;
            word_count_q  <= '0;
            cpu_mdr_out_q <= '0;
`ifdef FB_LOADER_CHECKSUM_EN
            sum_q         <= '0;
`endif
        end else begin
            state_q       <= state_d;
            word_count_q  <= word_count_d;
            cpu_mdr_out_q <= cpu_mdr_out_d;
`ifdef FB_LOADER_CHECKSUM_EN
            sum_q         <= sum_d;
`endif
        end
    end

    // NOTE: the RAM has no reset; word_count masking makes stale contents invisible to the CPU.
    always_ff @(posedge clk) begin
        if (mem_we) mem[mem_waddr] <= mem_wdata;
    end

endmodule

// File: tb/tb_fb_ram_loader.sv
// Self-checking bench for fb_ram_loader: load, overflow, reset-abort and CPU RAM access via a vector table.
// Checksum scenarios run only when FB_LOADER_CHECKSUM_EN is defined for the build.
module tb_fb_ram_loader;

    logic       clk = 1'b0;
    logic       rst;
    logic       ld_valid;
    logic [9:0] ld_data;
    logic       ld_last;
    logic       ld_ready;
    logic       cpu_rst;
    logic       load_done;
    logic       load_err;
    logic [6:0] word_count;
    logic [5:0] cpu_mar;
    logic [9:0] cpu_mdr_in;
    logic       cpu_ram_wr;
    logic [9:0] cpu_mdr_out;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [5:0] mar;
        logic       wr;
        logic [9:0] wdata;
        logic [9:0] exp_rd;
        logic [6:0] exp_wc;
    } vec_t;

    vec_t       vecs [10];
    logic [9:0] sb_q [$];

    fb_ram_loader #(.ADDRESS_WIDTH(6), .DATA_WIDTH(10)) dut (
        .clk        (clk),
        .rst        (rst),
        .ld_valid   (ld_valid),
        .ld_data    (ld_data),
        .ld_last    (ld_last),
        .ld_ready   (ld_ready),
        .cpu_rst    (cpu_rst),
        .load_done  (load_done),
        .load_err   (load_err),
        .word_count (word_count),
        .cpu_mar    (cpu_mar),
        .cpu_mdr_in (cpu_mdr_in),
        .cpu_ram_wr (cpu_ram_wr),
        .cpu_mdr_out(cpu_mdr_out)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic reset_dut();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic send_word(input logic [9:0] d, input logic last);
        ld_valid = 1'b1;
        ld_data  = d;
        ld_last  = last;
        tick();
        ld_valid = 1'b0;
        ld_last  = 1'b0;
    endtask

    // With the checksum feature the image is followed by its modulo sum; otherwise nothing.
    task automatic finish_load(input logic [9:0] sum);
`ifdef FB_LOADER_CHECKSUM_EN
        check("check_state_cpu_rst", cpu_rst, 1);
        send_word(sum, 1'b0);
`else
        ld_data = sum;
`endif
    endtask

    initial begin
        vecs[0] = '{6'd1,  1'b0, 10'h000, 10'h002, 7'd3};
        vecs[1] = '{6'd5,  1'b0, 10'h000, 10'h000, 7'd3};
        vecs[2] = '{6'd10, 1'b1, 10'h155, 10'h000, 7'd11};
        vecs[3] = '{6'd10, 1'b0, 10'h000, 10'h155, 7'd11};
        vecs[4] = '{6'd0,  1'b0, 10'h000, 10'h001, 7'd11};
        vecs[5] = '{6'd2,  1'b1, 10'h2AA, 10'h003, 7'd11};
        vecs[6] = '{6'd2,  1'b0, 10'h000, 10'h2AA, 7'd11};
        vecs[7] = '{6'd63, 1'b1, 10'h3FF, 10'h000, 7'd64};
        vecs[8] = '{6'd63, 1'b0, 10'h000, 10'h3FF, 7'd64};
        vecs[9] = '{6'd10, 1'b0, 10'h000, 10'h155, 7'd64};

        ld_valid = 1'b0; ld_data = '0; ld_last = 1'b0;
        cpu_mar = '0; cpu_mdr_in = '0; cpu_ram_wr = 1'b0;

        // Reset state
        reset_dut();
        check("rst_ld_ready",  ld_ready, 1);
        check("rst_cpu_rst",   cpu_rst, 1);
        check("rst_load_done", load_done, 0);
        check("rst_load_err",  load_err, 0);
        check("rst_wc",        word_count, 0);
        check("rst_mdr",       cpu_mdr_out, 0);

        // Three-word program; CPU writes while loading must be ignored
        cpu_ram_wr = 1'b1; cpu_mar = 6'd40; cpu_mdr_in = 10'h123;
        send_word(10'h001, 1'b0);
        cpu_ram_wr = 1'b0;
        check("load_wc1",  word_count, 1);
        check("load_mdr0", cpu_mdr_out, 0);
        send_word(10'h002, 1'b0);
        check("load_cpu_rst_before_last", cpu_rst, 1);
        send_word(10'h003, 1'b1);
        finish_load(10'h006);
        check("run_wc",        word_count, 3);
        check("run_cpu_rst",   cpu_rst, 0);
        check("run_load_done", load_done, 1);
        check("run_ld_ready",  ld_ready, 0);

        // CPU access table, read results flow through the scoreboard
        for (int i = 0; i < 10; i++) begin
            cpu_mar    = vecs[i].mar;
            cpu_ram_wr = vecs[i].wr;
            cpu_mdr_in = vecs[i].wdata;
            sb_q.push_back(vecs[i].exp_rd);
            tick();
            if (sb_q.size() == 0) check("sb_empty", 1, 0);
            else check($sformatf("vec%0d_rd", i), cpu_mdr_out, sb_q.pop_front());
            check($sformatf("vec%0d_wc", i), word_count, vecs[i].exp_wc);
        end
        cpu_ram_wr = 1'b0;

        // Overflow: 64 words with ld_last never set
        reset_dut();
        for (int i = 0; i < 63; i++) send_word(10'(i + 7), 1'b0);
        check("ovf_wc63",    word_count, 63);
        check("ovf_ready63", ld_ready, 1);
        send_word(10'h3AB, 1'b0);
        check("ovf_wc",      word_count, 64);
        check("ovf_err",     load_err, 1);
        check("ovf_cpu_rst", cpu_rst, 1);
        check("ovf_ready",   ld_ready, 0);
        check("ovf_done",    load_done, 0);
        ld_valid = 1'b1; cpu_ram_wr = 1'b1; cpu_mar = 6'd0; cpu_mdr_in = 10'h0FF;
        tick();
        tick();
        ld_valid = 1'b0; cpu_ram_wr = 1'b0;
        check("err_sticky", load_err, 1);
        check("err_wc",     word_count, 64);
        check("err_mdr",    cpu_mdr_out, 0);

        // Gapped load aborted by rst, then a one-word reload
        reset_dut();
        send_word(10'h011, 1'b0);
        tick();
        check("gap_hold1", word_count, 1);
        send_word(10'h022, 1'b0);
        tick();
        check("gap_hold2", word_count, 2);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("abort_wc",    word_count, 0);
        check("abort_ready", ld_ready, 1);
        send_word(10'h0AB, 1'b1);
        finish_load(10'h0AB);
        check("reload_done", load_done, 1);
        check("reload_wc",   word_count, 1);
        cpu_mar = 6'd0;
        sb_q.push_back(10'h0AB);
        tick();
        check("reload_rd0", cpu_mdr_out, sb_q.pop_front());
        cpu_mar = 6'd1;
        sb_q.push_back(10'h000);
        tick();
        check("reload_rd1_hidden", cpu_mdr_out, sb_q.pop_front());

`ifdef FB_LOADER_CHECKSUM_EN
        // Checksum wraps modulo 2^10: 0x3FF + 0x002 = 0x001
        reset_dut();
        send_word(10'h3FF, 1'b0);
        send_word(10'h002, 1'b1);
        check("cks_ready", ld_ready, 1);
        check("cks_hold",  load_done, 0);
        send_word(10'h001, 1'b0);
        check("cks_ok_done", load_done, 1);
        check("cks_ok_wc",   word_count, 2);
        reset_dut();
        send_word(10'h3FF, 1'b0);
        send_word(10'h002, 1'b1);
        send_word(10'h000, 1'b0);
        check("cks_bad_err",  load_err, 1);
        check("cks_bad_done", load_done, 0);
        check("cks_bad_rst",  cpu_rst, 1);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
